adc_to_frame_bram: RTL and testbench

Ingests raw XADC samples, oversamples them by a power-of-two boxcar sum, and writes each result into the 4096-entry circular frame BRAM that feeds the FFT streaming stage. Maintains the circular-buffer `head`, the address of the oldest stored sample. Pulses `start` once per hop of new samples after the buffer has been filled once. Sits between the XADC wrapper and `bram_to_fft`.

---
 rtl/frame_pkg.sv | 18 +
 rtl/adc_to_frame_bram_if.sv | 41 ++++
 rtl/adc_to_frame_bram_accum.sv | 51 +++++
 rtl/adc_to_frame_bram.sv | 139 +++++++++++++
 tb/tb_adc_to_frame_bram.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Constants shared by every block that touches the circular frame BRAM:
// adc_to_frame_bram, bram_to_fft and the FFT wrapper.
// Also holds the writer's FSM state type.
// -----------------------------------------------------------------------------
package frame_pkg;

    localparam int FRAME_ADDR_W = 12;
    localparam int FRAME_DATA_W = 16;
    localparam int FRAME_LEN    = 1 << FRAME_ADDR_W;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } frame_state_t;

endpackage

// File: rtl/adc_to_frame_bram_if.sv
// -----------------------------------------------------------------------------
// adc_to_frame_bram_if
// Bundles the sample input strobe and the frame-BRAM write / frame-status
// outputs of adc_to_frame_bram.
//   slave  : the frame writer (takes samples, drives BRAM port and status)
//   master : the environment (XADC side source, BRAM / reader side sink)
// Signals:
//   sample_valid, sample          raw ADC strobe and code
//   bram_we, bram_addr, bram_din  frame BRAM write port
//   head                          oldest-sample address
//   start                         one-cycle "new frame ready" pulse
//   filled                        frame has been written once since reset
// -----------------------------------------------------------------------------
interface adc_to_frame_bram_if
    import frame_pkg::*;
#(
    parameter int IN_W   = 12,
    parameter int ADDR_W = FRAME_ADDR_W,
    parameter int DATA_W = FRAME_DATA_W
);

    logic              sample_valid;
    logic [IN_W-1:0]   sample;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic [ADDR_W-1:0] head;
    logic              start;
    logic              filled;

    modport master (
        output sample_valid, sample,
        input  bram_we, bram_addr, bram_din, head, start, filled
    );

    modport slave (
        input  sample_valid, sample,
        output bram_we, bram_addr, bram_din, head, start, filled
    );

endinterface

// File: rtl/adc_to_frame_bram_accum.sv
// -----------------------------------------------------------------------------
// oversample_accum
// Power-of-two boxcar sum of raw ADC samples.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   sample_valid  input strobe
//   sample        raw unsigned code (zero-extended into the sum)
//   acc_valid     combinational: this valid completes a block of 2^OSR_LOG2
//   acc_word      combinational: top DATA_W bits of the completed sum
// The completed word is presented in the same cycle as the final valid so the
// top level can register it straight onto the BRAM port one cycle later.
// -----------------------------------------------------------------------------
module oversample_accum
    import frame_pkg::*;
#(
    parameter int IN_W     = 12,
    parameter int OSR_LOG2 = 4,
    parameter int DATA_W   = FRAME_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [IN_W-1:0]   sample,
    output logic              acc_valid,
    output logic [DATA_W-1:0] acc_word
);

    localparam int ACC_W = IN_W + OSR_LOG2;

    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    sum;
    logic [OSR_LOG2-1:0] cnt;

    always_comb begin
        sum       = acc + {{OSR_LOG2{1'b0}}, sample};
        acc_valid = sample_valid && (cnt == '1);
        acc_word  = sum[ACC_W-1 -: DATA_W];
    end

    // The final sample of a block is consumed into acc_word and not carried.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (sample_valid) begin
            cnt <= cnt + 1'b1;
            acc <= (cnt == '1) ? '0 : sum;
        end
    end

endmodule

// File: rtl/adc_to_frame_bram.sv
// -----------------------------------------------------------------------------
// adc_to_frame_bram
// Oversamples raw XADC samples and writes the results into the circular frame
// BRAM, tracking the oldest-sample pointer (head) and pulsing start once per
// HOP new words after the buffer has been filled once.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus         adc_to_frame_bram_if.slave (samples in, BRAM write + status out)
//   clip_clr    clears the sticky clip flag
//   clip        sticky ADC-rail flag
// Build option: define ADC_FRAME_CLIP_EN to build the clip detector; without
// it clip is tied low and clip_clr is ignored.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_FILL | buffer not yet full; no start pulses
// ST_RUN  | buffer full; start every HOP written words
// -----------------------------------------------------------------------------
module adc_to_frame_bram
    import frame_pkg::*;
#(
    parameter int IN_W     = 12,
    parameter int OSR_LOG2 = 4,
    parameter int ADDR_W   = FRAME_ADDR_W,
    parameter int DATA_W   = FRAME_DATA_W,
    parameter int HOP      = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adc_to_frame_bram_if.slave   bus,
    input  logic                 clip_clr,
    output logic                 clip
);

    localparam logic [ADDR_W-1:0] HOP_M1 = ADDR_W'(HOP - 1);

    logic              acc_valid;
    logic [DATA_W-1:0] acc_word;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] hop_cnt;
    frame_state_t      state;
    frame_state_t      state_nxt;
    logic              enter_run;
    logic              hop_hit;
    logic              start_d;

    oversample_accum #(
        .IN_W     (IN_W),
        .OSR_LOG2 (OSR_LOG2),
        .DATA_W   (DATA_W)
    ) u_accum (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (bus.sample_valid),
        .sample       (bus.sample),
        .acc_valid    (acc_valid),
        .acc_word     (acc_word)
    );

    // wr_ptr advances as the write retires, so it already names the next
    // word to be overwritten, which is exactly the oldest stored sample.
    assign bus.head = wr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (enter_run) begin
            state_nxt = ST_RUN;
        end
    end

    // Decisions are taken on the BRAM write cycle so start lands together
    // with the updated head, after the word is committed.
    always_comb begin
        enter_run = (state == ST_FILL) && bus.bram_we && (bus.bram_addr == '1);
        hop_hit   = (state == ST_RUN) && bus.bram_we && (hop_cnt == HOP_M1);
        start_d   = enter_run || hop_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bram_we   <= 1'b0;
            bus.bram_addr <= '0;
            bus.bram_din  <= '0;
            bus.start     <= 1'b0;
            bus.filled    <= 1'b0;
            wr_ptr        <= '0;
            hop_cnt       <= '0;
        end else begin
            bus.bram_we <= acc_valid;
            if (acc_valid) begin
                bus.bram_addr <= wr_ptr;
                bus.bram_din  <= acc_word;
            end
            if (bus.bram_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            bus.start <= start_d;
            if (enter_run) begin
                bus.filled <= 1'b1;
            end
            if (start_d) begin
                hop_cnt <= '0;
            end else if ((state == ST_RUN) && bus.bram_we) begin
                hop_cnt <= hop_cnt + 1'b1;
            end
        end
    end

`ifdef ADC_FRAME_CLIP_EN
    logic rail;

    assign rail = bus.sample_valid && ((bus.sample == '0) || (bus.sample == '1));

    // A rail hit wins over a simultaneous clear so no event is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip <= 1'b0;
        end else if (rail) begin
            clip <= 1'b1;
        end else if (clip_clr) begin
            clip <= 1'b0;
        end
    end
`else
    logic unused_clip_clr;

    assign unused_clip_clr = clip_clr;
    assign clip            = 1'b0;
`endif

endmodule

// File: tb/tb_adc_to_frame_bram.sv
// -----------------------------------------------------------------------------
// tb_adc_to_frame_bram
// Bench for adc_to_frame_bram, built with a 256-word frame and HOP of 64 so
// full fill / hop / rate-comparison scenarios stay short. A reference model in
// send() pushes each expected BRAM write to a queue; a negedge monitor pops
// and compares writes, head updates and start pulses.
// -----------------------------------------------------------------------------
module tb_adc_to_frame_bram;

    localparam int IN_W     = 12;
    localparam int OSR_LOG2 = 4;
    localparam int OSR      = 1 << OSR_LOG2;
    localparam int ACC_W    = IN_W + OSR_LOG2;
    localparam int ADDR_W   = 8;
    localparam int FRAME    = 1 << ADDR_W;
    localparam int DATA_W   = 16;
    localparam int HOP      = 64;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
        logic              st;
    } wr_t;

    logic clk;
    logic rst_n;
    logic clip_clr;
    logic clip;

    adc_to_frame_bram_if #(.IN_W(IN_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    adc_to_frame_bram #(
        .IN_W     (IN_W),
        .OSR_LOG2 (OSR_LOG2),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .HOP      (HOP)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .clip_clr (clip_clr),
        .clip     (clip)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // reference model
    int  m_acc   = 0;
    int  m_cnt   = 0;
    int  m_ptr   = 0;
    int  m_words = 0;
    wr_t exp_q[$];

    // monitor state
    int                wr_count  = 0;
    int                start_log[$];
    logic              prev_we   = 1'b0;
    logic              prev_st   = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    logic [DATA_W-1:0] mem   [FRAME];
    logic [DATA_W-1:0] mem_a [FRAME];
    int                log_a[$];

    always @(negedge clk) begin
        wr_t e;
        if (!rst_n) begin
            prev_we = 1'b0;
        end else begin
            if (prev_we) begin
                n_checks++;
                if (bus.head !== prev_addr + 1'b1)
                    $display("FAIL head_after_write: got %0d want %0d", bus.head, prev_addr + 1'b1);
                else n_pass++;
                n_checks++;
                if (bus.start !== prev_st)
                    $display("FAIL start_after_write: got %b want %b (write %0d)", bus.start, prev_st, wr_count);
                else n_pass++;
            end else begin
                n_checks++;
                if (bus.start !== 1'b0)
                    $display("FAIL start_idle: got %b want 0", bus.start);
                else n_pass++;
            end
            if (bus.start === 1'b1) start_log.push_back(wr_count);
            if (bus.bram_we === 1'b1) begin
                n_checks++;
                if (prev_we)
                    $display("FAIL we_spacing: bram_we got 1 in consecutive cycles, want gap");
                else n_pass++;
                wr_count++;
                mem[bus.bram_addr] = bus.bram_din;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_write: got addr %0d din %h want no write", bus.bram_addr, bus.bram_din);
                    prev_st = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    if (bus.bram_addr !== e.addr || bus.bram_din !== e.din)
                        $display("FAIL write: got addr %0d din %h want addr %0d din %h",
                                 bus.bram_addr, bus.bram_din, e.addr, e.din);
                    else n_pass++;
                    prev_st = e.st;
                end
                prev_addr = bus.bram_addr;
            end
            prev_we = (bus.bram_we === 1'b1);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [IN_W-1:0] s);
        wr_t e;
        bus.sample_valid = 1'b1;
        bus.sample       = s;
        m_acc += int'(s);
        m_cnt++;
        if (m_cnt == OSR) begin
            m_words++;
            e.addr = ADDR_W'(m_ptr);
            e.din  = DATA_W'(m_acc >> (ACC_W - DATA_W));
            e.st   = (m_words == FRAME) || (m_words > FRAME && ((m_words - FRAME) % HOP) == 0);
            exp_q.push_back(e);
            m_ptr = (m_ptr + 1) % FRAME;
            m_acc = 0;
            m_cnt = 0;
        end
        step();
        bus.sample_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n            = 1'b0;
        bus.sample_valid = 1'b1;
        bus.sample       = '0;
        clip_clr         = 1'b0;
        step();
        n_checks++;
        if (bus.bram_we !== 1'b0) $display("FAIL rst_bram_we: got %b want 0", bus.bram_we); else n_pass++;
        n_checks++;
        if (bus.bram_addr !== '0) $display("FAIL rst_bram_addr: got %0d want 0", bus.bram_addr); else n_pass++;
        n_checks++;
        if (bus.bram_din !== '0) $display("FAIL rst_bram_din: got %h want 0", bus.bram_din); else n_pass++;
        n_checks++;
        if (bus.head !== '0) $display("FAIL rst_head: got %0d want 0", bus.head); else n_pass++;
        n_checks++;
        if (bus.start !== 1'b0) $display("FAIL rst_start: got %b want 0", bus.start); else n_pass++;
        n_checks++;
        if (bus.filled !== 1'b0) $display("FAIL rst_filled: got %b want 0", bus.filled); else n_pass++;
        n_checks++;
        if (clip !== 1'b0) $display("FAIL rst_clip: got %b want 0", clip); else n_pass++;
        bus.sample_valid = 1'b0;
        repeat (2) step();
        m_acc = 0; m_cnt = 0; m_ptr = 0; m_words = 0;
        exp_q.delete();
        start_log.delete();
        wr_count = 0;
        for (int i = 0; i < FRAME; i++) mem[i] = '0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic check_drained(input string tag);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL %s_pending: got %0d outstanding writes want 0", tag, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_basic();
        repeat (OSR) send(12'h800);
        step();
        n_checks++;
        if (bus.head !== ADDR_W'(1)) $display("FAIL basic_head: got %0d want 1", bus.head); else n_pass++;
        n_checks++;
        if (bus.start !== 1'b0) $display("FAIL basic_start: got %b want 0", bus.start); else n_pass++;
        n_checks++;
        if (mem[0] !== 16'h8000) $display("FAIL basic_din: got %h want 8000", mem[0]); else n_pass++;
        n_checks++;
        if (bus.filled !== 1'b0) $display("FAIL basic_filled: got %b want 0", bus.filled); else n_pass++;
        check_drained("basic");
    endtask

    task automatic test_fill();
        while (m_words < FRAME) send(12'hFFF);
        repeat (3) step();
        n_checks++;
        if (bus.filled !== 1'b1) $display("FAIL fill_filled: got %b want 1", bus.filled); else n_pass++;
        n_checks++;
        if (bus.head !== '0) $display("FAIL fill_head: got %0d want 0", bus.head); else n_pass++;
        n_checks++;
        if (mem[FRAME-1] !== 16'hFFF0) $display("FAIL fill_last_din: got %h want fff0", mem[FRAME-1]); else n_pass++;
        n_checks++;
        if (start_log.size() != 1)
            $display("FAIL fill_start_count: got %0d want 1", start_log.size());
        else if (start_log[0] != FRAME)
            $display("FAIL fill_start_pos: got %0d want %0d", start_log[0], FRAME);
        else n_pass++;
        check_drained("fill");
    endtask

    task automatic test_hop();
        repeat ((HOP / 2) * OSR) send(12'hFFF);
        n_checks++;
        if (start_log.size() != 1) $display("FAIL hop_mid_start_count: got %0d want 1", start_log.size()); else n_pass++;
        repeat ((HOP / 2) * OSR) send(12'hFFF);
        repeat (3) step();
        n_checks++;
        if (start_log.size() != 2)
            $display("FAIL hop_start_count: got %0d want 2", start_log.size());
        else if (start_log[1] != FRAME + HOP)
            $display("FAIL hop_start_pos: got %0d want %0d", start_log[1], FRAME + HOP);
        else n_pass++;
        n_checks++;
        if (bus.head !== ADDR_W'(HOP)) $display("FAIL hop_head: got %0d want %0d", bus.head, HOP); else n_pass++;
        check_drained("hop");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        repeat (9) send(12'h123);
        apply_reset();
        repeat (OSR) send(12'h001);
        step();
        n_checks++;
        if (mem[0] !== 16'h0010) $display("FAIL rstmid_din: got %h want 0010", mem[0]); else n_pass++;
        n_checks++;
        if (bus.head !== ADDR_W'(1)) $display("FAIL rstmid_head: got %0d want 1", bus.head); else n_pass++;
        check_drained("rstmid");
    endtask

    task automatic test_clip();
        apply_reset();
`ifdef ADC_FRAME_CLIP_EN
        send(12'h000);
        n_checks++;
        if (clip !== 1'b1) $display("FAIL clip_set: got %b want 1", clip); else n_pass++;
        repeat (3) step();
        n_checks++;
        if (clip !== 1'b1) $display("FAIL clip_hold: got %b want 1", clip); else n_pass++;
        clip_clr = 1'b1;
        step();
        clip_clr = 1'b0;
        n_checks++;
        if (clip !== 1'b0) $display("FAIL clip_clr: got %b want 0", clip); else n_pass++;
        send(12'h800);
        n_checks++;
        if (clip !== 1'b0) $display("FAIL clip_midscale: got %b want 0", clip); else n_pass++;
        clip_clr = 1'b1;
        send(12'hFFF);
        clip_clr = 1'b0;
        n_checks++;
        if (clip !== 1'b1) $display("FAIL clip_clr_vs_event: got %b want 1", clip); else n_pass++;
`else
        send(12'h000);
        send(12'hFFF);
        repeat (2) step();
        n_checks++;
        if (clip !== 1'b0) $display("FAIL clip_disabled: got %b want 0", clip); else n_pass++;
`endif
    endtask

    task automatic run_ramp(input int gap);
        for (int i = 0; i < (FRAME + 2 * HOP) * OSR; i++) begin
            send(IN_W'(i));
            repeat (gap) step();
        end
        repeat (4) step();
    endtask

    task automatic test_rate_match();
        int mism;
        apply_reset();
        run_ramp(0);
        check_drained("ramp_fast");
        for (int i = 0; i < FRAME; i++) mem_a[i] = mem[i];
        log_a = start_log;
        apply_reset();
        run_ramp(6);
        check_drained("ramp_slow");
        mism = 0;
        for (int i = 0; i < FRAME; i++) begin
            n_checks++;
            if (mem[i] !== mem_a[i]) begin
                if (mism < 8) $display("FAIL ramp_mem[%0d]: got %h want %h", i, mem[i], mem_a[i]);
                mism++;
            end else n_pass++;
        end
        n_checks++;
        if (start_log.size() != 3 || log_a.size() != 3)
            $display("FAIL ramp_start_count: got %0d/%0d want 3/3", start_log.size(), log_a.size());
        else if (start_log[0] != log_a[0] || start_log[1] != log_a[1] || start_log[2] != log_a[2])
            $display("FAIL ramp_start_pos: got %0d,%0d,%0d want %0d,%0d,%0d",
                     start_log[0], start_log[1], start_log[2], log_a[0], log_a[1], log_a[2]);
        else n_pass++;
    endtask

    initial begin
        rst_n            = 1'b0;
        clip_clr         = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        test_reset();
        test_basic();
        test_fill();
        test_hop();
        test_reset_mid();
        test_clip();
        test_rate_match();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
